// File: rtl/lsu_writeback_unit.sv
// Completion stage for one instruction: ALU results go straight to writeback, while loads and
// stores run a req/gnt/rvalid memory handshake first. Only one instruction is in flight at a time.
module lsu_writeback_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic [4:0]  RD,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] RS2_DATA,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, ERR} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wbd_q, wbd_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;

  logic        accept, is_alu, is_ld, is_st, aligned, ld_ok, st_ok;
  logic [1:0]  off;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept = in_valid & (state_q == IDLE);
  assign off    = ALU_RESULT[1:0];
  assign is_alu = (OPCODE == 7'b0010011) | (OPCODE == 7'b0110011) |
                  (OPCODE == 7'b0110111) | (OPCODE == 7'b0010111);
  assign is_ld  = (OPCODE == 7'b0000011);
  assign is_st  = (OPCODE == 7'b0100011);

  always_comb begin
    aligned  = 1'b0;
    st_strb  = 4'b0000;
    st_wdata = 32'h0;
    case (FUNCT3[1:0])
      2'b00: begin aligned = 1'b1;        st_strb = 4'b0001 << off; st_wdata = {4{RS2_DATA[7:0]}};  end
      2'b01: begin aligned = ~off[0];     st_strb = 4'b0011 << off; st_wdata = {2{RS2_DATA[15:0]}}; end
      2'b10: begin aligned = (off == 2'b00); st_strb = 4'b1111;     st_wdata = RS2_DATA;             end
      default: ;
    endcase
  end

  assign ld_ok = aligned & (FUNCT3 != 3'b011) & (FUNCT3 != 3'b110) & (FUNCT3 != 3'b111);
  assign st_ok = aligned & ~FUNCT3[2];

  // Lane extraction uses the byte offset saved at accept, since mem_addr is word-aligned.
  assign ld_byte = mem_rdata[8*off_q +: 8];
  assign ld_half = mem_rdata[16*off_q[1] +: 16];
  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wbd_q   <= 32'h0;
      wstrb_q <= 4'h0;
      f3_q    <= 3'h0;
      off_q   <= 2'h0;
      rd_q    <= 5'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wbd_q   <= wbd_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (is_alu)     state_d = WB;
        else if (is_ld) state_d = ld_ok ? REQ : ERR;
        else if (is_st) state_d = st_ok ? REQ : ERR;
      end
      REQ:  if (mem_gnt) state_d = we_q ? IDLE : WAIT;
      // Data arriving on the expiry cycle takes priority over the timeout.
      WAIT: if (mem_rvalid) state_d = WB;
            else if (cnt_q == 16'(TIMEOUT - 1)) state_d = ERR;
      WB:   state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wbd_d   = wbd_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept && (is_alu || is_ld || is_st)) begin
        rd_d = RD;
        f3_d = FUNCT3;
        if (is_alu) wbd_d = ALU_RESULT;
        else begin
          off_d   = off;
          addr_d  = {ALU_RESULT[31:2], 2'b00};
          we_d    = is_st;
          wstrb_d = is_st ? st_strb : 4'h0;
          wdata_d = is_st ? st_wdata : 32'h0;
        end
      end
      REQ:  if (mem_gnt) cnt_d = 16'h0;
      WAIT: if (mem_rvalid) wbd_d = ld_data;
            else cnt_d = cnt_q + 16'h1;
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_req   = (state_q == REQ);
    mem_we    = (state_q == REQ) & we_q;
    mem_wstrb = (state_q == REQ) ? wstrb_q : 4'h0;
    wb_en     = (state_q == WB) & (rd_q != 5'h0);
    err       = (state_q == ERR);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wbd_q;

endmodule

// File: tb/tb_lsu_writeback_unit.sv
// Directed bench for lsu_writeback_unit with hand-computed expectations.
module tb_lsu_writeback_unit;
  localparam int TO = 6;

  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [6:0]  OPCODE = 0;
  logic [2:0]  FUNCT3 = 0;
  logic [4:0]  RD = 0;
  logic [31:0] ALU_RESULT = 0, RS2_DATA = 0;
  logic        mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wstrb;
  logic        wb_en, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_tests = 0, n_fail = 0;

  lsu_writeback_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3), .RD(RD), .ALU_RESULT(ALU_RESULT), .RS2_DATA(RS2_DATA),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one instruction for a single accept edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2);
    OPCODE = op; FUNCT3 = f3; RD = rd; ALU_RESULT = alu; RS2_DATA = rs2; in_valid = 1;
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] rdata, input logic [31:0] exp);
    issue(7'b0000011, f3, 5'd7, addr, 0);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_strb"}, mem_wstrb, 0);
    mem_gnt = 1; tick(); mem_gnt = 0;
    chk({tag, "_req_drop"}, mem_req, 0);
    mem_rvalid = 1; mem_rdata = rdata; tick(); mem_rvalid = 0;
    chk({tag, "_wben"}, wb_en, 1);
    chk({tag, "_wbrd"}, wb_rd, 7);
    chk({tag, "_data"}, wb_data, exp);
    tick();
    chk({tag, "_wben_off"}, wb_en, 0);
  endtask

  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input int gdly, input logic [3:0] strb,
                       input logic [31:0] wd);
    int req_cycles = 0;
    issue(7'b0100011, f3, 5'd3, addr, rs2);
    for (int i = 0; i < gdly; i++) begin
      req_cycles += int'(mem_req);
      tick();
    end
    mem_gnt = 1;
    req_cycles += int'(mem_req);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_strb"}, mem_wstrb, strb);
    chk({tag, "_wdata"}, mem_wdata, wd);
    chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    tick(); mem_gnt = 0;
    chk({tag, "_req_cycles"}, req_cycles, gdly + 1);
    chk({tag, "_req_drop"}, mem_req, 0);
    chk({tag, "_no_wb"}, wb_en, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_wben", wb_en, 0);
    chk("rst_err", err, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_addr", mem_addr, 0);
    #20 rst_n = 1;
    tick();

    issue(7'b0010011, 3'b000, 5'd5, 32'h1234, 0);
    chk("addi_wben", wb_en, 1);
    chk("addi_rd", wb_rd, 5);
    chk("addi_data", wb_data, 32'h1234);
    chk("addi_busy", in_ready, 0);
    tick();
    chk("addi_pulse", wb_en, 0);
    issue(7'b0110011, 3'b000, 5'd0, 32'hABCD, 0);
    chk("rd0_wben", wb_en, 0);
    tick();

    load("lb",  3'b000, 32'h103, 32'h80FF_7F01, 32'hFFFF_FF80);
    load("lbu", 3'b100, 32'h103, 32'h80FF_7F01, 32'h0000_0080);
    load("lhu", 3'b101, 32'h102, 32'h80FF_7F01, 32'h0000_80FF);
    load("lh",  3'b001, 32'h100, 32'h1234_8001, 32'hFFFF_8001);
    load("lw",  3'b010, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);

    store("sh", 3'b001, 32'h206, 32'hDEAD_BEEF, 3, 4'b1100, 32'hBEEF_BEEF);
    store("sb", 3'b000, 32'h301, 32'h1234_5678, 0, 4'b0010, 32'h7878_7878);

    issue(7'b0000011, 3'b010, 5'd9, 32'h101, 0);
    chk("mis_err", err, 1);
    chk("mis_req", mem_req, 0);
    chk("mis_wb", wb_en, 0);
    tick();
    chk("mis_pulse", err, 0);
    chk("mis_ready", in_ready, 1);
    issue(7'b0000011, 3'b011, 5'd9, 32'h100, 0);
    chk("illf3_err", err, 1);
    tick();
    issue(7'b1111111, 3'b000, 5'd9, 32'h100, 0);
    chk("unk_ready", in_ready, 1);
    chk("unk_req", mem_req, 0);
    chk("unk_wb", wb_en, 0);

    // Timeout: TO cycles in WAIT without rvalid, then a stray rvalid in IDLE.
    issue(7'b0000011, 3'b010, 5'd4, 32'h100, 0);
    mem_gnt = 1; tick(); mem_gnt = 0;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_early", err, 0);
    tick();
    chk("to_err", err, 1);
    chk("to_wb", wb_en, 0);
    mem_rvalid = 1; tick(); mem_rvalid = 0;
    chk("to_pulse", err, 0);
    chk("late_rv_wb", wb_en, 0);
    chk("late_rv_ready", in_ready, 1);

    // rvalid on the final WAIT cycle beats the timeout.
    issue(7'b0000011, 3'b010, 5'd4, 32'h100, 0);
    mem_gnt = 1; tick(); mem_gnt = 0;
    for (int i = 0; i < TO - 1; i++) tick();
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; tick(); mem_rvalid = 0;
    chk("edge_err", err, 0);
    chk("edge_wb", wb_en, 1);
    chk("edge_data", wb_data, 32'h5555_AAAA);
    tick();

    // Reset in WAIT.
    issue(7'b0000011, 3'b010, 5'd6, 32'h108, 0);
    mem_gnt = 1; tick(); mem_gnt = 0;
    rst_n = 0; #1;
    chk("rstw_ready", in_ready, 1);
    chk("rstw_req", mem_req, 0);
    chk("rstw_addr", mem_addr, 0);
    chk("rstw_data", wb_data, 0);
    #10 rst_n = 1;
    mem_rvalid = 1; tick(); mem_rvalid = 0;
    chk("rstw_no_wb", wb_en, 0);
    tick();
    chk("rstw_no_wb2", wb_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
